// File: rtl/im2col_csc_encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : im2col_pkg                                                     |
// | Purpose : Shared types and default geometry for the im2col CSC encoder.  |
// |           Provides the encoder FSM state enum, the default ROWS/COLS/    |
// |           DATA_W/CNT_W values and the CSC data-memory entry struct       |
// |           {run_count, value}.                                            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package im2col_pkg;

  localparam int DEF_DATA_W = 8;   // ifmap value width
  localparam int DEF_ROWS   = 4;   // values per im2col column
  localparam int DEF_COLS   = 25;  // columns per vector (weight_width^2)
  localparam int DEF_CNT_W  = 2;   // run_count width, $clog2(DEF_ROWS)

  // Encoder sequencing: ENCODE consumes values, the two tail states emit
  // the final address entry and then the end sign.
  typedef enum logic [1:0] {
    ENCODE    = 2'd0,
    TAIL_ADDR = 2'd1,
    TAIL_END  = 2'd2
  } state_t;

  // One data-memory entry for the default geometry. An all-zero entry is
  // the end sign that terminates a vector.
  typedef struct packed {
    logic [DEF_CNT_W-1:0]  run_count;
    logic [DEF_DATA_W-1:0] value;
  } csc_entry_t;

endpackage
`default_nettype wire

// File: rtl/im2col_csc_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: im2col_csc_encoder_if                                         |
// | Purpose  : Input value stream plus the two CSC memory write ports of the |
// |            im2col CSC encoder.                                           |
// | Signals  : in_valid/in_ready/in_data   value stream (im2col order)       |
// |            data_wr_en/addr/data         data-memory write port           |
// |            addr_wr_en/addr/data         address-memory write port        |
// |            vector_done                  end-sign-written pulse           |
// | Modports : master - the encoder (drives in_ready and the write ports)    |
// |            slave  - the environment (drives the value stream)            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface im2col_csc_encoder_if
  import im2col_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DADDR_W = 7,
  parameter int AADDR_W = 5
);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;

  logic                    data_wr_en;
  logic [DADDR_W-1:0]      data_wr_addr;
  logic [CNT_W+DATA_W-1:0] data_wr_data;

  logic                    addr_wr_en;
  logic [AADDR_W-1:0]      addr_wr_addr;
  logic [DADDR_W-1:0]      addr_wr_data;

  logic                    vector_done;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output data_wr_en, data_wr_addr, data_wr_data,
    output addr_wr_en, addr_wr_addr, addr_wr_data,
    output vector_done
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  data_wr_en, data_wr_addr, data_wr_data,
    input  addr_wr_en, addr_wr_addr, addr_wr_data,
    input  vector_done
  );

endinterface
`default_nettype wire

// File: rtl/im2col_csc_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : im2col_csc_encoder                                             |
// | Purpose : Converts the im2col value stream (ROWS values per column, COLS |
// |           columns per vector, column-major) into CSC form. Each nonzero  |
// |           becomes a {run_count, value} data-memory entry; each column    |
// |           gets a cumulative nonzero count in the address memory; each    |
// |           vector ends with a final address entry and a zero end sign.    |
// | Ports   : clock, reset (synchronous, active-high)                        |
// |           bus          im2col_csc_encoder_if.master (stream + writes)    |
// |           zero_count   zeros in the last finished vector (optional)      |
// | Config  : IM2COL_CSC_ZERO_CNT_EN adds the zero_count output and counter. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module im2col_csc_encoder
  import im2col_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DADDR_W = 7,
  parameter int AADDR_W = 5
) (
  input  wire logic             clock,
  input  wire logic             reset,
  im2col_csc_encoder_if.master  bus
`ifdef IM2COL_CSC_ZERO_CNT_EN
  ,
  output logic [DADDR_W-1:0]    zero_count
`endif
);

  localparam int                 ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0]   C_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [AADDR_W-1:0] C_COL_LAST = AADDR_W'(COLS - 1);

  // Sequencing and counters
  state_t              r_state;
  logic                r_in_ready;
  logic [ROW_W-1:0]    r_row_cnt;
  logic [AADDR_W-1:0]  r_col_cnt;
  logic [CNT_W-1:0]    r_run_cnt;
  logic [DADDR_W-1:0]  r_nz_total;
`ifdef IM2COL_CSC_ZERO_CNT_EN
  logic [DADDR_W-1:0]  r_zero_acc;
  logic [DADDR_W-1:0]  r_zero_count;
`endif

  // Write-port register stage
  logic                    r_data_wr_en;
  logic [DADDR_W-1:0]      r_data_wr_addr;
  logic [CNT_W+DATA_W-1:0] r_data_wr_data;
  logic                    r_addr_wr_en;
  logic [AADDR_W-1:0]      r_addr_wr_addr;
  logic [DADDR_W-1:0]      r_addr_wr_data;
  logic                    r_vector_done;

  logic               w_accept;
  logic               w_nonzero;
  logic               w_col_end;
  logic               w_vec_end;
  logic [DADDR_W-1:0] w_nz_incl;

  // in_ready is a registered copy of (state == ENCODE), so accepting only
  // needs in_valid gated by it.
  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_nonzero = (bus.in_data != '0);
  assign w_col_end = (r_row_cnt == C_ROW_LAST);
  assign w_vec_end = w_col_end && (r_col_cnt == C_COL_LAST);
  // Nonzero count including the value being accepted this cycle.
  assign w_nz_incl = r_nz_total + DADDR_W'(w_nonzero);

  // FSM and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ENCODE;
      r_in_ready <= 1'b1;
      r_row_cnt  <= '0;
      r_col_cnt  <= '0;
      r_run_cnt  <= '0;
      r_nz_total <= '0;
`ifdef IM2COL_CSC_ZERO_CNT_EN
      r_zero_acc <= '0;
`endif
    end else begin
      unique case (r_state)
        ENCODE: begin
          if (w_accept) begin
            if (w_nonzero) begin
              r_nz_total <= w_nz_incl;
              r_run_cnt  <= '0;
            end else begin
              r_run_cnt  <= r_run_cnt + CNT_W'(1);
`ifdef IM2COL_CSC_ZERO_CNT_EN
              r_zero_acc <= r_zero_acc + DADDR_W'(1);
`endif
            end
            // A column end overrides the run update above, so run_cnt
            // never has to hold ROWS.
            if (w_col_end) begin
              r_row_cnt <= '0;
              r_run_cnt <= '0;
              r_col_cnt <= r_col_cnt + AADDR_W'(1);
            end else begin
              r_row_cnt <= r_row_cnt + ROW_W'(1);
            end
            if (w_vec_end) begin
              r_state    <= TAIL_ADDR;
              r_in_ready <= 1'b0;
            end
          end
        end
        TAIL_ADDR: begin
          r_state <= TAIL_END;
        end
        TAIL_END: begin
          r_state    <= ENCODE;
          r_in_ready <= 1'b1;
          r_nz_total <= '0;
          r_col_cnt  <= '0;
`ifdef IM2COL_CSC_ZERO_CNT_EN
          r_zero_acc <= '0;
`endif
        end
        default: begin
          r_state    <= ENCODE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Memory write ports, registered one cycle after their cause. Address
  // and data fields hold their last value while the strobe is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data_wr_en   <= 1'b0;
      r_data_wr_addr <= '0;
      r_data_wr_data <= '0;
      r_addr_wr_en   <= 1'b0;
      r_addr_wr_addr <= '0;
      r_addr_wr_data <= '0;
      r_vector_done  <= 1'b0;
`ifdef IM2COL_CSC_ZERO_CNT_EN
      r_zero_count   <= '0;
`endif
    end else begin
      r_data_wr_en  <= 1'b0;
      r_addr_wr_en  <= 1'b0;
      r_vector_done <= 1'b0;
      unique case (r_state)
        ENCODE: begin
          if (w_accept) begin
            if (w_nonzero) begin
              r_data_wr_en   <= 1'b1;
              r_data_wr_addr <= r_nz_total;
              r_data_wr_data <= {r_run_cnt, bus.in_data};
            end
            // The last column's entry is written by TAIL_ADDR instead.
            if (w_col_end && !w_vec_end) begin
              r_addr_wr_en   <= 1'b1;
              r_addr_wr_addr <= r_col_cnt;
              r_addr_wr_data <= w_nz_incl;
            end
          end
        end
        TAIL_ADDR: begin
          r_addr_wr_en   <= 1'b1;
          r_addr_wr_addr <= C_COL_LAST;
          r_addr_wr_data <= r_nz_total;
        end
        TAIL_END: begin
          r_data_wr_en   <= 1'b1;
          r_data_wr_addr <= r_nz_total;
          r_data_wr_data <= '0;
          r_vector_done  <= 1'b1;
`ifdef IM2COL_CSC_ZERO_CNT_EN
          r_zero_count   <= r_zero_acc;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.data_wr_en   = r_data_wr_en;
  assign bus.data_wr_addr = r_data_wr_addr;
  assign bus.data_wr_data = r_data_wr_data;
  assign bus.addr_wr_en   = r_addr_wr_en;
  assign bus.addr_wr_addr = r_addr_wr_addr;
  assign bus.addr_wr_data = r_addr_wr_data;
  assign bus.vector_done  = r_vector_done;
`ifdef IM2COL_CSC_ZERO_CNT_EN
  assign zero_count       = r_zero_count;
`endif

endmodule
`default_nettype wire
